// File: rtl/ysyx_23060187_ifu.sv
// Instruction fetch unit for the multi-cycle NPC core.
// One AXI4-Lite read per instruction, handed to decode, then waits for next PC.
module ysyx_23060187_ifu #(
  parameter int               XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            ifu_arvalid,
  output logic [XLEN-1:0] ifu_araddr,
  input  logic            ifu_arready,
  input  logic            ifu_rvalid,
  input  logic [XLEN-1:0] ifu_rdata,
  input  logic [1:0]      ifu_rresp,
  output logic            ifu_rready,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault,
  input  logic            inst_ready,
  input  logic            npc_valid,
  input  logic [XLEN-1:0] npc,
  output logic [31:0]     fetch_cnt
);

  localparam logic [2:0] S_BOOT = 3'd0;
  localparam logic [2:0] S_REQ  = 3'd1;
  localparam logic [2:0] S_RESP = 3'd2;
  localparam logic [2:0] S_OUT  = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;

  logic [2:0]      state;
  logic [2:0]      state_nxt;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] inst_q;
  logic            fault_q;
  logic [31:0]     cnt;

  logic ar_hs;
  logic r_hs;
  logic out_hs;
  logic npc_hs;
  logic npc_mis;

  assign ar_hs   = (state == S_REQ)  && ifu_arready;
  assign r_hs    = (state == S_RESP) && ifu_rvalid;
  assign out_hs  = (state == S_OUT)  && inst_ready;
  assign npc_hs  = (state == S_WAIT) && npc_valid;
  assign npc_mis = npc[1:0] != 2'b00;

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_BOOT: state_nxt = S_REQ;
      S_REQ:  if (ar_hs)  state_nxt = S_RESP;
      S_RESP: if (r_hs)   state_nxt = S_OUT;
      S_OUT:  if (out_hs) state_nxt = S_WAIT;
      S_WAIT: begin
        if (npc_hs)
          state_nxt = npc_mis ? S_OUT : S_REQ;
      end
      default: state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_BOOT;
      pc      <= RESET_PC;
      inst_q  <= '0;
      fault_q <= 1'b0;
      cnt     <= '0;
    end else begin
      state <= state_nxt;
      if (r_hs) begin
        inst_q  <= (ifu_rresp == 2'b00) ? ifu_rdata : '0;
        fault_q <= ifu_rresp != 2'b00;
      end
      if (out_hs)
        cnt <= cnt + 32'd1;
      // Misaligned target skips the bus and is reported as a faulted inst.
      if (npc_hs) begin
        pc <= npc;
        if (npc_mis) begin
          inst_q  <= '0;
          fault_q <= 1'b1;
        end
      end
    end
  end

  assign ifu_arvalid = state == S_REQ;
  assign ifu_rready  = state == S_RESP;
  assign inst_valid  = state == S_OUT;
  assign ifu_araddr  = pc;
  assign inst_pc     = pc;
  assign inst        = inst_q;
  assign inst_fault  = fault_q;
  assign fetch_cnt   = cnt;

endmodule

// File: tb/tb_ysyx_23060187_ifu.sv
// Bench for ysyx_23060187_ifu: transaction-level model, bus responder,
// directed scenarios with literal expectations.
module tb_ysyx_23060187_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic        ifu_arvalid;
  logic [31:0] ifu_araddr;
  logic        ifu_arready;
  logic        ifu_rvalid;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        ifu_rready;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_fault;
  logic        inst_ready;
  logic        npc_valid;
  logic [31:0] npc;
  logic [31:0] fetch_cnt;

  ysyx_23060187_ifu #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_arvalid(ifu_arvalid), .ifu_araddr(ifu_araddr),
    .ifu_arready(ifu_arready), .ifu_rvalid(ifu_rvalid),
    .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
    .ifu_rready(ifu_rready), .inst_valid(inst_valid),
    .inst(inst), .inst_pc(inst_pc), .inst_fault(inst_fault),
    .inst_ready(inst_ready), .npc_valid(npc_valid), .npc(npc),
    .fetch_cnt(fetch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] mem_word(logic [31:0] a);
    if (a == RST_PC) return 32'h0000_0413;
    return a ^ 32'h1357_0013;
  endfunction

  // Responder knobs
  int          ar_delay  = 0;
  int          r_delay   = 0;
  int          rdy_delay = 0;
  bit          noise     = 0;
  logic [1:0]  resp_cfg  = 2'b00;
  logic [31:0] npc_q[$];

  // Transaction-level model
  logic [31:0] m_pc    = RST_PC;
  logic [31:0] m_inst  = '0;
  logic        m_fault = 1'b0;
  logic [31:0] m_cnt   = '0;
  bit          m_wait  = 0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_pc = RST_PC; m_inst = '0; m_fault = 1'b0;
      m_cnt = '0; m_wait = 0;
    end else begin
      if (ifu_rready && ifu_rvalid) begin
        m_fault = ifu_rresp != 2'b00;
        m_inst  = m_fault ? 32'h0 : mem_word(m_pc);
      end
      if (inst_valid && inst_ready) begin
        m_cnt  = m_cnt + 1;
        m_wait = 1;
      end else if (m_wait && npc_valid) begin
        m_wait = 0;
        m_pc   = npc;
        if (npc[1:0] != 2'b00) begin
          m_inst  = '0;
          m_fault = 1'b1;
        end
      end
    end
  end

  // Compare every cycle outside reset
  always @(negedge clk) begin
    if (rst_n) begin
      chk("excl", 32'($countones({ifu_arvalid, ifu_rready, inst_valid}) <= 1), 1);
      chk("araddr", ifu_araddr, m_pc);
      chk("inst_pc", inst_pc, m_pc);
      chk("fetch_cnt", fetch_cnt, m_cnt);
      if (inst_valid) begin
        chk("inst", inst, m_inst);
        chk("inst_fault", 32'(inst_fault), 32'(m_fault));
      end
      if (m_wait) chk("idle_in_wait", 32'(ifu_arvalid | inst_valid), 0);
    end
  end

  // Bus / decode / execute responder
  int ar_cnt, r_cnt, o_cnt;
  initial begin
    ifu_arready = 0; ifu_rvalid = 0; ifu_rdata = '0; ifu_rresp = '0;
    inst_ready = 0; npc_valid = 0; npc = '0;
    ar_cnt = 0; r_cnt = 0; o_cnt = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        ifu_arready = 0; ifu_rvalid = 0; inst_ready = 0; npc_valid = 0;
        ar_cnt = 0; r_cnt = 0; o_cnt = 0;
      end else begin
        if (ifu_arvalid) begin
          ifu_arready = ar_cnt >= ar_delay; ar_cnt++;
        end else begin
          ar_cnt = 0;
          ifu_arready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        if (ifu_rready) begin
          ifu_rvalid = r_cnt >= r_delay; r_cnt++;
          ifu_rdata  = ifu_rvalid ? mem_word(ifu_araddr) : $urandom;
          ifu_rresp  = ifu_rvalid ? resp_cfg : 2'($urandom);
        end else begin
          r_cnt = 0;
          ifu_rvalid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
          ifu_rdata  = $urandom;
          ifu_rresp  = 2'($urandom);
        end
        if (inst_valid) begin
          inst_ready = o_cnt >= rdy_delay; o_cnt++;
        end else begin
          o_cnt = 0;
          inst_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        if (m_wait && npc_q.size() > 0) begin
          npc_valid = 1; npc = npc_q.pop_front();
        end else begin
          npc_valid = (noise && !m_wait) ? 1'($urandom_range(0, 1)) : 1'b0;
          npc = $urandom;
        end
      end
    end
  end

  task automatic wait_iv(int max, output int n_ar, output int n_r);
    bit seen = 0;
    n_ar = 0; n_r = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (inst_valid) begin seen = 1; break; end
      if (ifu_arvalid) n_ar++;
      if (ifu_rready) n_r++;
    end
    chk("inst_valid_timeout", 32'(seen), 1);
  endtask

  int na, nr, nv;

  initial begin
    rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_arvalid", 32'(ifu_arvalid), 0);
    chk("rst_rready", 32'(ifu_rready), 0);
    chk("rst_inst_valid", 32'(inst_valid), 0);
    chk("rst_araddr", ifu_araddr, 32'h8000_0000);
    chk("rst_inst_pc", inst_pc, 32'h8000_0000);
    chk("rst_cnt", fetch_cnt, 0);
    chk("rst_fault", 32'(inst_fault), 0);

    // 1: boot then immediate fetch
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk); chk("t1_boot", 32'(ifu_arvalid), 0);
    @(negedge clk); chk("t1_arvalid", 32'(ifu_arvalid), 1);
    chk("t1_araddr", ifu_araddr, 32'h8000_0000);
    @(negedge clk); chk("t1_rready", 32'(ifu_rready), 1);
    @(negedge clk); chk("t1_valid", 32'(inst_valid), 1);
    chk("t1_inst", inst, 32'h0000_0413);
    chk("t1_pc", inst_pc, 32'h8000_0000);
    chk("t1_cnt0", fetch_cnt, 0);
    @(negedge clk); chk("t1_cnt1", fetch_cnt, 1);
    chk("t1_drop", 32'(inst_valid), 0);

    // 2: slow address and data
    ar_delay = 3; r_delay = 2;
    npc_q.push_back(32'h8000_0004);
    wait_iv(50, na, nr);
    chk("t2_ar_cycles", na, 4);
    chk("t2_r_cycles", nr, 3);
    chk("t2_inst", inst, 32'h9357_0017);
    ar_delay = 0; r_delay = 0;

    // 3: decode stalls with bus noise
    rdy_delay = 4; noise = 1;
    npc_q.push_back(32'h8000_0008);
    wait_iv(50, na, nr);
    nv = 0;
    while (inst_valid && nv < 20) begin nv++; @(negedge clk); end
    chk("t3_valid_cycles", nv, 5);
    chk("t3_cnt", fetch_cnt, 3);
    repeat (4) begin
      @(negedge clk); chk("t3_no_ar", 32'(ifu_arvalid), 0);
    end
    noise = 0; rdy_delay = 0;

    // 4: jump, then misaligned target
    npc_q.push_back(32'h8000_0010);
    nv = 0;
    while (!ifu_arvalid && nv < 20) begin nv++; @(negedge clk); end
    chk("t4_araddr", ifu_araddr, 32'h8000_0010);
    wait_iv(50, na, nr);
    npc_q.push_back(32'h8000_0006);
    wait_iv(50, na, nr);
    chk("t4_mis_no_ar", na, 0);
    chk("t4_mis_fault", 32'(inst_fault), 1);
    chk("t4_mis_inst", inst, 0);
    chk("t4_mis_pc", inst_pc, 32'h8000_0006);

    // 5: access fault with stray handshakes
    noise = 1; resp_cfg = 2'b10;
    npc_q.push_back(32'h8000_0020);
    wait_iv(50, na, nr);
    chk("t5_fault", 32'(inst_fault), 1);
    chk("t5_inst", inst, 0);
    chk("t5_pc", inst_pc, 32'h8000_0020);
    noise = 0; resp_cfg = 2'b00;
    @(negedge clk); chk("t5_cnt", fetch_cnt, 6);

    // 6: reset while waiting for data
    r_delay = 3;
    npc_q.push_back(32'h8000_0030);
    nv = 0;
    while (!ifu_rready && nv < 20) begin nv++; @(negedge clk); end
    chk("t6_in_resp", 32'(ifu_rready), 1);
    #1 rst_n = 0;
    #1;
    chk("t6_rready_drop", 32'(ifu_rready), 0);
    chk("t6_arvalid_drop", 32'(ifu_arvalid), 0);
    chk("t6_valid_drop", 32'(inst_valid), 0);
    npc_q.delete();
    r_delay = 0;
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk); chk("t6_boot", 32'(ifu_arvalid), 0);
    chk("t6_cnt0", fetch_cnt, 0);
    @(negedge clk); chk("t6_arvalid", 32'(ifu_arvalid), 1);
    chk("t6_araddr", ifu_araddr, 32'h8000_0000);
    wait_iv(20, na, nr);
    chk("t6_inst", inst, 32'h0000_0413);
    @(negedge clk); chk("t6_cnt1", fetch_cnt, 1);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
